pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Consumes hazard_detection's
//  load-use and flag-wait requests, the ID-stage branch decision and HLT decode; drives
//  PC/IF-ID write enables, IF-ID flush, ID-EX bubble. Owns halt drain, stall watchdog, perf counters.
// PARAMETERS
//  CNT_W      16  width of saturating perf counters
//  DRAIN_MAX  3   cycles allowed for HLT to travel ID->WB (EX, MEM, WB)
//  STALL_MAX  2   max legal consecutive stall cycles before stall_err
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  hz_load_use  in   1      load-use dependency on ID operand (from hazard_detection)
//  hz_flag      in   1      conditional branch in ID waits on flag-setting op in EX
//  br_taken     in   1      branch/jump in ID resolved taken (valid only when not stalling)
//  d_halt       in   1      HLT opcode decoded in ID
//  w_halt       in   1      HLT instruction retiring in WB
//  pc_we        out  1      PC register write enable
//  ifid_we      out  1      IF/ID pipeline register write enable
//  ifid_flush   out  1      load NOP into IF/ID next edge
//  idex_bubble  out  1      load NOP (all ctrl 0) into ID/EX next edge
//  halted       out  1      processor halted (sticky until reset)
//  stall_err    out  1      sticky: consecutive stalls exceeded STALL_MAX
//  drain_err    out  1      sticky: w_halt not seen within DRAIN_MAX cycles
//  stall_cnt    out  CNT_W  saturating count of stall cycles
//  flush_cnt    out  CNT_W  saturating count of taken-branch flushes
// BEHAVIOUR
//  States: RUN, DRAIN, HALTED (2-bit). Reset: RUN, all counters/errs 0, halted 0.
//  While rst_n low all outputs 0 (pc_we/ifid_we gated by rst_n).
//  Control outputs are combinational from state + inputs (same-cycle effect); state, counters registered.
//  RUN, priority order:
//   1) stall = hz_load_use|hz_flag: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0;
//      br_taken and d_halt ignored this cycle (ID instr re-evaluated next cycle).
//   2) d_halt: pc_we=0, ifid_we=1, ifid_flush=1; -> DRAIN, drain_ctr<=0. HLT passes into EX.
//   3) br_taken: pc_we=1, ifid_we=1, ifid_flush=1; flush_cnt++.
//   4) else pc_we=1, ifid_we=1, others 0.
//  DRAIN: pc_we=0, ifid_we=1, ifid_flush=1, idex_bubble=0; drain_ctr++ each cycle.
//   w_halt -> HALTED (w_halt wins over timeout same cycle);
//   drain_ctr==DRAIN_MAX-1 w/o w_halt -> HALTED, drain_err<=1. hz_*/br_taken ignored.
//  HALTED: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, halted=1; exit only by reset.
//  stall_run counter: ++ per RUN stall cycle, cleared on non-stall cycle, saturates;
//   stall_err<=1 when stall_run reaches STALL_MAX while stall still asserted (cycle STALL_MAX+1).
//  stall_cnt ++ each RUN stall cycle; both perf counters saturate at 2^CNT_W-1, never wrap.
//  w_halt in RUN: protocol violation, ignored. Reset mid-DRAIN: returns to RUN, counters cleared.
// STRUCTURE
//  pipe_ctrl_pkg: state enum {RUN=2'd0, DRAIN=2'd1, HALTED=2'd2}, default param values, HLT opcode 4'hF.
//  Sub-module sat_counter #(W) (clk, rst_n, inc, clr, q): used for stall_cnt, flush_cnt, stall_run.
// TESTING
//  Reset release, no inputs -> cycle 1 pc_we=1, ifid_we=1, flushes/bubble 0, counters 0.
//  hz_load_use 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle; stall_cnt=1; no stall_err.
//  hz_flag=1 and br_taken=1 same cycle, then br_taken alone -> stall first, flush second; flush_cnt=1.
//  hz_load_use held 3 cycles -> stall_err=1 after 3rd edge, stays 1 after release; stall_cnt=3.
//  d_halt, w_halt 3 cycles later -> DRAIN 3 cycles w/ ifid_flush=1, then halted=1, drain_err=0, pc_we=0.
//  d_halt, no w_halt -> halted=1 and drain_err=1 after DRAIN_MAX cycles; rst_n low mid-DRAIN -> RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int CNT_W_DEF     = 16;
  localparam int DRAIN_MAX_DEF = 3;
  localparam int STALL_MAX_DEF = 2;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard requests in, pipeline register controls and status out
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             hz_load_use;
  logic             hz_flag;
  logic             br_taken;
  logic             d_halt;
  logic             w_halt;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic             stall_err;
  logic             drain_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // master is the datapath side raising requests; slave is the sequencer
  modport master (
    output hz_load_use, hz_flag, br_taken, d_halt, w_halt,
    input  pc_we, ifid_we, ifid_flush, idex_bubble,
    input  halted, stall_err, drain_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hz_load_use, hz_flag, br_taken, d_halt, w_halt,
    output pc_we, ifid_we, ifid_flush, idex_bubble,
    output halted, stall_err, drain_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer with halt drain, stall watchdog and perf counters
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF,
  parameter int STALL_MAX = STALL_MAX_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam int RUN_W   = $clog2(STALL_MAX + 2);
  localparam int DRAIN_W = $clog2(DRAIN_MAX) + 1;

  state_t             state;
  logic [DRAIN_W-1:0] drain_ctr;
  logic [RUN_W-1:0]   stall_run;
  logic               stall_err_q;
  logic               drain_err_q;

  logic in_run;
  logic run_stall;
  logic run_flush;

  assign in_run    = (state == RUN);
  assign run_stall = in_run && (bus.hz_load_use || bus.hz_flag);
  // a stall masks the branch and HLT; the ID instruction is re-evaluated next cycle
  assign run_flush = in_run && !run_stall && !bus.d_halt && bus.br_taken;

  always_comb begin
    bus.pc_we       = 1'b0;
    bus.ifid_we     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (run_stall) begin
            bus.idex_bubble = 1'b1;
          end else if (bus.d_halt) begin
            bus.ifid_we    = 1'b1;
            bus.ifid_flush = 1'b1;
          end else begin
            bus.pc_we      = 1'b1;
            bus.ifid_we    = 1'b1;
            bus.ifid_flush = bus.br_taken;
          end
        end
        DRAIN: begin
          bus.ifid_we    = 1'b1;
          bus.ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      drain_ctr   <= '0;
      stall_err_q <= 1'b0;
      drain_err_q <= 1'b0;
    end else begin
      if (run_stall && (stall_run >= RUN_W'(STALL_MAX))) begin
        stall_err_q <= 1'b1;
      end
      case (state)
        RUN: begin
          if (!run_stall && bus.d_halt) begin
            state     <= DRAIN;
            drain_ctr <= '0;
          end
        end
        DRAIN: begin
          if (bus.w_halt) begin
            state <= HALTED;
          end else if (drain_ctr == DRAIN_W'(DRAIN_MAX - 1)) begin
            state       <= HALTED;
            drain_err_q <= 1'b1;
          end else begin
            drain_ctr <= drain_ctr + 1'b1;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(RUN_W)) u_stall_run (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_stall),
    .clr   (!run_stall),
    .q     (stall_run)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_stall),
    .clr   (1'b0),
    .q     (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_flush),
    .clr   (1'b0),
    .q     (bus.flush_cnt)
  );

  assign bus.halted    = (state == HALTED);
  assign bus.stall_err = stall_err_q;
  assign bus.drain_err = drain_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_failed;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_ctrl #(.CNT_W(16), .DRAIN_MAX(3), .STALL_MAX(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lu, input logic fl, input logic br, input logic dh, input logic wh);
    bus.hz_load_use = lu;
    bus.hz_flag     = fl;
    bus.br_taken    = br;
    bus.d_halt      = dh;
    bus.w_halt      = wh;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic ctrl(input string tag, input logic pc, input logic ifid, input logic fl, input logic bub);
    check({tag, ".pc_we"}, 32'(bus.pc_we), 32'(pc));
    check({tag, ".ifid_we"}, 32'(bus.ifid_we), 32'(ifid));
    check({tag, ".ifid_flush"}, 32'(bus.ifid_flush), 32'(fl));
    check({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'(bub));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0);

    // reset asserted: everything low
    tick();
    tick();
    mid();
    ctrl("in_reset", 0, 0, 0, 0);
    check("in_reset.halted", 32'(bus.halted), 0);
    rst_n = 1'b1;

    // first cycle after release
    mid();
    ctrl("run_idle", 1, 1, 0, 0);
    check("run_idle.stall_cnt", 32'(bus.stall_cnt), 0);
    check("run_idle.flush_cnt", 32'(bus.flush_cnt), 0);
    tick();

    // single load-use stall
    drive(1, 0, 0, 0, 0);
    mid();
    ctrl("lu1", 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("lu1.stall_cnt", 32'(bus.stall_cnt), 1);
    check("lu1.stall_err", 32'(bus.stall_err), 0);

    // flag stall masks taken branch, then branch flushes
    drive(0, 1, 1, 0, 0);
    mid();
    ctrl("flag_br", 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0);
    mid();
    ctrl("br", 1, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("br.flush_cnt", 32'(bus.flush_cnt), 1);
    check("br.stall_cnt", 32'(bus.stall_cnt), 2);

    // w_halt in RUN is ignored
    drive(0, 0, 0, 0, 1);
    mid();
    ctrl("whalt_run", 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("whalt_run.halted", 32'(bus.halted), 0);

    // three consecutive stalls trip the watchdog on the third edge
    drive(1, 0, 0, 0, 0);
    tick();
    check("wd1.stall_err", 32'(bus.stall_err), 0);
    tick();
    check("wd2.stall_err", 32'(bus.stall_err), 0);
    tick();
    check("wd3.stall_err", 32'(bus.stall_err), 1);
    drive(0, 0, 0, 0, 0);
    tick();
    check("wd_rel.stall_err", 32'(bus.stall_err), 1);
    check("wd_rel.stall_cnt", 32'(bus.stall_cnt), 5);

    // halt with w_halt on third drain cycle
    drive(0, 0, 0, 1, 0);
    mid();
    ctrl("hlt_id", 0, 1, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0);
    mid();
    ctrl("drain1", 0, 1, 1, 0);
    tick();
    check("drain1.stall_cnt", 32'(bus.stall_cnt), 5);
    check("drain1.flush_cnt", 32'(bus.flush_cnt), 1);
    drive(0, 0, 0, 0, 0);
    mid();
    ctrl("drain2", 0, 1, 1, 0);
    check("drain2.halted", 32'(bus.halted), 0);
    tick();
    drive(0, 0, 0, 0, 1);
    mid();
    ctrl("drain3", 0, 1, 1, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    check("halt.halted", 32'(bus.halted), 1);
    check("halt.drain_err", 32'(bus.drain_err), 0);
    mid();
    ctrl("halted", 0, 0, 0, 0);
    tick();
    check("halted.flush_cnt", 32'(bus.flush_cnt), 1);
    check("halted.sticky", 32'(bus.halted), 1);

    // halt with no w_halt: drain timeout
    do_reset();
    check("rst.stall_err", 32'(bus.stall_err), 0);
    check("rst.stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst.halted", 32'(bus.halted), 0);
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("to2.halted", 32'(bus.halted), 0);
    tick();
    check("to3.halted", 32'(bus.halted), 1);
    check("to3.drain_err", 32'(bus.drain_err), 1);

    // reset in the middle of a drain returns to RUN
    do_reset();
    check("rst2.drain_err", 32'(bus.drain_err), 0);
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    mid();
    ctrl("mid_drain", 0, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    ctrl("mid_drain_rst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    mid();
    ctrl("after_rst", 1, 1, 0, 0);
    check("after_rst.halted", 32'(bus.halted), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
